// File: rtl/qracc_pkg.sv
// Shared types and default timing for the QR-accelerator digital blocks.
package qracc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRECH,
        WRITE,
        SENSE,
        CAPTURE
    } sram_ctrl_state_t;

    localparam int SRAM_PCH_CYCLES  = 2;
    localparam int SRAM_WR_CYCLES   = 3;
    localparam int SRAM_SAEN_CYCLES = 2;
    localparam int SRAM_CNT_W       = 8;

endpackage

// File: rtl/qracc_sram_ctrl_wl_onehot_decoder.sv
// Row address to one-hot wordline; addresses past NUM_ROWS decode to zero.
module wl_onehot_decoder #(
    parameter  int NUM_ROWS = 128,
    localparam int AW       = $clog2(NUM_ROWS)
) (
    input  logic [AW-1:0]       i_addr,
    input  logic                i_en,
    output logic [NUM_ROWS-1:0] o_wl
);

    always_comb begin
        o_wl = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (i_en && (i_addr == AW'(i))) begin
                o_wl[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qracc_sram_ctrl.sv
// Phase sequencer for single-word reads and writes on the QR-accelerator
// SRAM macro; all macro controls are registered and decoded from state.
module qracc_sram_ctrl
    import qracc_pkg::*;
#(
    parameter  int numRows     = 128,
    parameter  int numCols     = 32,
    parameter  int PCH_CYCLES  = SRAM_PCH_CYCLES,
    parameter  int WR_CYCLES   = SRAM_WR_CYCLES,
    parameter  int SAEN_CYCLES = SRAM_SAEN_CYCLES,
    localparam int AW          = $clog2(numRows)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rq_wr_i,
    input  logic               rq_valid_i,
    output logic               rq_ready_o,
    input  logic [AW-1:0]      addr_i,
    input  logic [numCols-1:0] wr_data_i,
    output logic               rd_valid_o,
    output logic [numCols-1:0] rd_data_o,
    output logic [numRows-1:0] WL,
    output logic               PCH,
    output logic               WRITE,
    output logic [numCols-1:0] WR_DATA,
    output logic [numCols-1:0] CSEL,
    output logic               SAEN,
    input  logic [numCols-1:0] SA_OUT
);

    sram_ctrl_state_t        r_state;
    logic [SRAM_CNT_W-1:0]   r_cnt;
    logic                    r_wr;
    logic [AW-1:0]           r_addr;
    logic [numCols-1:0]      r_data;
    logic [numRows-1:0]      w_wl;
    logic                    w_oor;

    wl_onehot_decoder #(
        .NUM_ROWS (numRows)
    ) u_wl_dec (
        .i_addr (r_addr),
        .i_en   (1'b1),
        .o_wl   (w_wl)
    );

    // An address with no matching row reads back as zero.
    assign w_oor      = ~|w_wl;
    assign rq_ready_o = (r_state == qracc_pkg::IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= qracc_pkg::IDLE;
            r_cnt      <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
            WL         <= '0;
            PCH        <= 1'b0;
            WRITE      <= 1'b0;
            WR_DATA    <= '0;
            CSEL       <= '0;
            SAEN       <= 1'b0;
        end else begin
            rd_valid_o <= 1'b0;
            unique case (r_state)
                qracc_pkg::IDLE: begin
                    if (rq_valid_i) begin
                        r_wr    <= rq_wr_i;
                        r_addr  <= addr_i;
                        r_data  <= wr_data_i;
                        r_cnt   <= SRAM_CNT_W'(PCH_CYCLES - 1);
                        PCH     <= 1'b1;
                        r_state <= qracc_pkg::PRECH;
                    end
                end
                qracc_pkg::PRECH: begin
                    if (r_cnt == '0) begin
                        PCH  <= 1'b0;
                        WL   <= w_wl;
                        CSEL <= '1;
                        if (r_wr) begin
                            r_cnt   <= SRAM_CNT_W'(WR_CYCLES - 1);
                            WRITE   <= 1'b1;
                            WR_DATA <= r_data;
                            r_state <= qracc_pkg::WRITE;
                        end else begin
                            r_cnt   <= SRAM_CNT_W'(SAEN_CYCLES - 1);
                            SAEN    <= 1'b1;
                            r_state <= qracc_pkg::SENSE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                qracc_pkg::WRITE: begin
                    if (r_cnt == '0) begin
                        WL      <= '0;
                        WRITE   <= 1'b0;
                        WR_DATA <= '0;
                        CSEL    <= '0;
                        r_state <= qracc_pkg::IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                qracc_pkg::SENSE: begin
                    if (r_cnt == '0) begin
                        WL         <= '0;
                        SAEN       <= 1'b0;
                        CSEL       <= '0;
                        rd_valid_o <= 1'b1;
                        rd_data_o  <= w_oor ? '0 : SA_OUT;
                        r_state    <= qracc_pkg::CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                qracc_pkg::CAPTURE: begin
                    r_state <= qracc_pkg::IDLE;
                end
                default: begin
                    r_state <= qracc_pkg::IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Directed bench for qracc_sram_ctrl: a 128-row instance and a 100-row
// instance sharing clock and reset.
module tb_qracc_sram_ctrl;

    logic         clk = 1'b0;
    logic         rst;

    logic         rq_wr, rq_valid, rq_ready;
    logic [6:0]   addr;
    logic [31:0]  wr_data, rd_data, wr_dout, csel, sa_out;
    logic         rd_valid, pch, wrt, saen;
    logic [127:0] wl;

    logic         b_wr, b_valid, b_ready;
    logic [6:0]   b_addr;
    logic [31:0]  b_wr_data, b_rd_data, b_wr_dout, b_csel, b_sa;
    logic         b_rd_valid, b_pch, b_wrt, b_saen;
    logic [99:0]  b_wl;

    int total = 0;
    int bad   = 0;

    logic [127:0] one = 128'd1;
    logic [99:0]  wl_or;
    int           pulses;

    always #5 clk = ~clk;

    qracc_sram_ctrl #(.numRows(128), .numCols(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .rq_wr_i    (rq_wr),
        .rq_valid_i (rq_valid),
        .rq_ready_o (rq_ready),
        .addr_i     (addr),
        .wr_data_i  (wr_data),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data),
        .WL         (wl),
        .PCH        (pch),
        .WRITE      (wrt),
        .WR_DATA    (wr_dout),
        .CSEL       (csel),
        .SAEN       (saen),
        .SA_OUT     (sa_out)
    );

    qracc_sram_ctrl #(.numRows(100), .numCols(32)) u_dut100 (
        .clk        (clk),
        .rst        (rst),
        .rq_wr_i    (b_wr),
        .rq_valid_i (b_valid),
        .rq_ready_o (b_ready),
        .addr_i     (b_addr),
        .wr_data_i  (b_wr_data),
        .rd_valid_o (b_rd_valid),
        .rd_data_o  (b_rd_data),
        .WL         (b_wl),
        .PCH        (b_pch),
        .WRITE      (b_wrt),
        .WR_DATA    (b_wr_dout),
        .CSEL       (b_csel),
        .SAEN       (b_saen),
        .SA_OUT     (b_sa)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        rq_wr = 1'b0; rq_valid = 1'b0; addr = '0; wr_data = '0; sa_out = '0;
        b_wr = 1'b0; b_valid = 1'b0; b_addr = '0; b_wr_data = '0; b_sa = '0;
        repeat (2) tick();

        // reset state
        chk("rst_ready", rq_ready, 0);
        chk("rst_wl", wl, 0);
        chk("rst_pch", pch, 0);
        chk("rst_write", wrt, 0);
        chk("rst_saen", saen, 0);
        chk("rst_csel", csel, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_rdd", rd_data, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", rq_ready, 1);

        // 1: write addr 5
        rq_wr = 1'b1; addr = 7'd5; wr_data = 32'hDEADBEEF; rq_valid = 1'b1;
        tick();
        rq_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("w1_pch_c%0d", c), pch, (c <= 2));
            chk($sformatf("w1_write_c%0d", c), wrt, (c >= 3 && c <= 5));
            chk($sformatf("w1_wl_c%0d", c), wl,
                (c >= 3 && c <= 5) ? (one << 5) : 128'd0);
            chk($sformatf("w1_wrd_c%0d", c), wr_dout,
                (c >= 3 && c <= 5) ? 32'hDEADBEEF : 32'd0);
            chk($sformatf("w1_ready_c%0d", c), rq_ready, (c == 6));
            if (c == 3) chk("w1_csel", csel, 32'hFFFFFFFF);
            if (c == 3) chk("w1_saen", saen, 0);
            if (c < 6) tick();
        end
        chk("w1_rdd_untouched", rd_data, 0);

        // 2: read addr 5
        rq_wr = 1'b0; addr = 7'd5; sa_out = 32'hDEADBEEF; rq_valid = 1'b1;
        tick();
        rq_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("r2_pch_c%0d", c), pch, (c <= 2));
            chk($sformatf("r2_saen_c%0d", c), saen, (c == 3 || c == 4));
            chk($sformatf("r2_wl_c%0d", c), wl,
                (c == 3 || c == 4) ? (one << 5) : 128'd0);
            chk($sformatf("r2_write_c%0d", c), wrt, 0);
            chk($sformatf("r2_rdv_c%0d", c), rd_valid, (c == 5));
            chk($sformatf("r2_ready_c%0d", c), rq_ready, (c == 6));
            if (c == 5) chk("r2_rdd", rd_data, 32'hDEADBEEF);
            if (c < 6) tick();
        end
        sa_out = 32'h0;
        repeat (4) tick();
        chk("r2_rdd_hold_c10", rd_data, 32'hDEADBEEF);

        // 3: back-to-back read addr 0 then write addr 127
        rq_wr = 1'b0; addr = 7'd0; sa_out = 32'h12345678; rq_valid = 1'b1;
        tick();
        rq_wr = 1'b1; addr = 7'd127; wr_data = 32'hA5A55A5A;
        tick(); tick();
        chk("b3_wl0_c3", wl, one);
        chk("b3_saen_c3", saen, 1);
        tick(); tick();
        chk("b3_rdv_c5", rd_valid, 1);
        chk("b3_rdd_c5", rd_data, 32'h12345678);
        tick();
        chk("b3_ready_c6", rq_ready, 1);
        tick();
        rq_valid = 1'b0;
        sa_out = 32'hFFFF0000;
        chk("b3_pch_c7", pch, 1);
        chk("b3_ready_c7", rq_ready, 0);
        tick(); tick();
        chk("b3_wl127_c9", wl, one << 127);
        chk("b3_write_c9", wrt, 1);
        chk("b3_wrd_c9", wr_dout, 32'hA5A55A5A);
        chk("b3_rdd_keep_c9", rd_data, 32'h12345678);
        repeat (3) tick();
        chk("b3_ready_c12", rq_ready, 1);
        chk("b3_rdd_keep_c12", rd_data, 32'h12345678);

        // 4: inputs toggled while busy are ignored
        rq_wr = 1'b1; addr = 7'd10; wr_data = 32'h11111111; rq_valid = 1'b1;
        tick();
        rq_valid = 1'b0;
        rq_wr = 1'b0; addr = 7'd21; wr_data = 32'h22222222;
        tick();
        rq_wr = 1'b1; addr = 7'd22; wr_data = 32'h33333333;
        tick();
        chk("t4_write_c3", wrt, 1);
        chk("t4_saen_c3", saen, 0);
        chk("t4_wl_c3", wl, one << 10);
        chk("t4_wrd_c3", wr_dout, 32'h11111111);
        repeat (3) tick();
        chk("t4_ready_c6", rq_ready, 1);
        rq_wr = 1'b0;

        // 5: reset during SENSE of a read
        addr = 7'd7; sa_out = 32'hCAFEF00D; rq_valid = 1'b1;
        tick();
        rq_valid = 1'b0;
        tick(); tick();
        chk("t5_saen_c3", saen, 1);
        rst = 1'b1;
        tick();
        chk("t5_saen_c4", saen, 0);
        chk("t5_wl_c4", wl, 0);
        chk("t5_csel_c4", csel, 0);
        chk("t5_rdv_c4", rd_valid, 0);
        chk("t5_rdd_c4", rd_data, 0);
        chk("t5_ready_in_rst", rq_ready, 0);
        rst = 1'b0;
        #1;
        chk("t5_ready_after", rq_ready, 1);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rd_valid) pulses++;
        end
        chk("t5_no_pulse", pulses, 0);
        chk("t5_rdd_cleared", rd_data, 0);

        // 6: out-of-range read on the 100-row instance
        b_wr = 1'b0; b_addr = 7'd120; b_sa = 32'hFFFFFFFF; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        wl_or = '0;
        for (int c = 1; c <= 6; c++) begin
            wl_or |= b_wl;
            if (c == 3) chk("t6_saen_c3", b_saen, 1);
            if (c == 5) chk("t6_rdv_c5", b_rd_valid, 1);
            if (c == 5) chk("t6_rdd_c5", b_rd_data, 0);
            if (c == 6) chk("t6_ready_c6", b_ready, 1);
            if (c < 6) tick();
        end
        chk("t6_wl_never", wl_or, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qracc_sram_ctrl.md
Name: qracc_sram_ctrl

Overview:
- Sequences the QR-accelerator SRAM macro for single-word reads and writes.
- Accepts digital valid/ready requests on the SRAM slave interface signals and drives the macro's SRAM control fields (WL, PCH, WRITE, WR_DATA, CSEL, SAEN) with fixed, parameterised phase timing.
- Captures SA_OUT into the read-data register and reports completion with a one-cycle rd_valid_o pulse.
- Sits between the digital weight loader and the analog macro's SRAM port.

Parameters:
- numRows, 128, wordline count; address width is $clog2(numRows).
- numCols, 32, word width (bitlines per row).
- PCH_CYCLES, 2, precharge phase length in cycles; ≥1.
- WR_CYCLES, 3, write phase length in cycles; ≥1.
- SAEN_CYCLES, 2, sense phase length in cycles; ≥1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rq_wr_i  in  1  1 = write, 0 = read.
- rq_valid_i  in  1  request valid.
- rq_ready_o  out  1  controller can accept a request.
- addr_i  in  $clog2(numRows)  row address.
- wr_data_i  in  numCols  write data.
- rd_valid_o  out  1  one-cycle pulse; rd_data_o is valid.
- rd_data_o  out  numCols  last captured read word.
- WL  out  numRows  one-hot wordline.
- PCH  out  1  bitline precharge, active-high.
- WRITE  out  1  write-driver enable.
- WR_DATA  out  numCols  data driven onto the bitlines.
- CSEL  out  numCols  column select.
- SAEN  out  1  sense-amp enable.
- SA_OUT  in  numCols  sense-amp outputs from the macro.

Behaviour:
- Reset: clk and rst as named above; reset is synchronous and active-high. On any edge with rst=1:
  - state goes to IDLE;
  - all outputs are 0, including rd_data_o;
  - rq_ready_o = (state==IDLE) & ~rst, so it is 0 while rst is high.
- Accept: a request is taken on the edge where rq_valid_i & rq_ready_o. At that edge the controller latches rq_wr_i, addr_i and wr_data_i. Inputs are ignored at all other times.
- rq_ready_o is 1 only in IDLE. While it is 0, changes on the inputs have no effect.
- FSM states: IDLE, PRECH, WRITE, SENSE, CAPTURE. A phase down-counter is loaded on each state entry.
  - IDLE -> PRECH on accept.
  - PRECH: PCH=1 for PCH_CYCLES, then -> WRITE if the latched op is a write, else -> SENSE.
  - WRITE: WL one-hot at the latched address, WRITE=1, WR_DATA = latched data, CSEL all-ones, for WR_CYCLES; then -> IDLE.
  - SENSE: WL one-hot, SAEN=1, CSEL all-ones, for SAEN_CYCLES; then -> CAPTURE.
  - CAPTURE, one cycle:
    - rd_data_o <= SA_OUT as sampled on the last SENSE edge; i.e. SA_OUT is registered at the SENSE->CAPTURE transition.
    - rd_valid_o = 1 for exactly this cycle.
    - Then -> IDLE.
- Outputs are registered/Moore and decoded from state. PCH, WRITE, SAEN and WL are never asserted in the same cycle except WL with WRITE, or WL with SAEN. WL is all-zero outside WRITE and SENSE.
- rd_data_o holds its value until the next CAPTURE or reset. Writes never change it.
- Latency, with accept at edge 0:
  - write: ready reasserts after PCH_CYCLES+WR_CYCLES cycles;
  - read: rd_valid_o is high in cycle PCH_CYCLES+SAEN_CYCLES+1; ready reasserts the following cycle.
- Back-to-back: if rq_valid_i is held high, the next request is accepted on the first IDLE edge. There is no idle bubble beyond the single IDLE cycle.
- Out-of-range address (addr ≥ numRows, only possible when numRows is not a power of two):
  - timing is unchanged;
  - WL stays all-zero;
  - a write has no effect;
  - a read captures 0 regardless of SA_OUT.
- Reset mid-operation: the operation is aborted. Outputs are 0 in the cycle after the reset edge, no rd_valid_o pulse is produced, and rd_data_o is cleared.

Decomposition:
- qracc_pkg gains:
  - typedef enum logic [2:0] sram_ctrl_state_t {IDLE, PRECH, WRITE, SENSE, CAPTURE};
  - default timing constants SRAM_PCH_CYCLES, SRAM_WR_CYCLES, SRAM_SAEN_CYCLES.
- One sub-module: wl_onehot_decoder (address plus enable -> numRows one-hot output, all-zero when the address is out of range). It is reused later by the compute-mode row driver.

Test Plan (numRows=128, numCols=32, PCH=2, WR=3, SAEN=2):
1. Write addr=5, data=0xDEADBEEF accepted at edge 0 -> PCH=1 in cycles 1–2; WL[5]=1, WRITE=1, WR_DATA=0xDEADBEEF in cycles 3–5; rq_ready_o=1 again in cycle 6.
2. Read addr=5, bench drives SA_OUT=0xDEADBEEF during SENSE -> SAEN=1 and WL[5]=1 in cycles 3–4; rd_valid_o=1 only in cycle 5 with rd_data_o=0xDEADBEEF; rd_data_o is still 0xDEADBEEF in cycle 10.
3. rq_valid_i held high with a read to addr 0 then a write to addr 127 -> second request accepted on the first IDLE edge; WL[127] asserted; rd_data_o unchanged by the write.
4. addr_i and rq_wr_i toggled while rq_ready_o=0 -> no effect on WL or WR_DATA; the latched values are used.
5. rst pulsed in cycle 3 of a read -> all outputs 0 from cycle 4; no rd_valid_o pulse; rd_data_o=0; rq_ready_o=1 the cycle after rst falls.
6. numRows=100, read addr=120 with SA_OUT=0xFFFFFFFF -> WL all-zero throughout; rd_valid_o pulses with rd_data_o=0.
